// File: rtl/lfsr_gen_if.sv
// Control and status bundle for the lfsr_gen pseudo-random generator.
// The master drives step/load/mode; the slave returns state and period telemetry.
interface lfsr_gen_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             load;
  logic [WIDTH-1:0] seed_in;
  logic             mode;
  logic [WIDTH-1:0] out;
  logic             wrap;
  logic [WIDTH-1:0] period;
  logic             period_vld;
  logic             zero_err;

  modport master (
    output en, load, seed_in, mode,
    input  out, wrap, period, period_vld, zero_err
  );

  modport slave (
    input  en, load, seed_in, mode,
    output out, wrap, period, period_vld, zero_err
  );
endinterface

// File: rtl/lfsr_gen.sv
// WIDTH-bit LFSR with runtime Galois/Fibonacci selection, seed load with zero
// substitution, and period measurement against a re-settable anchor state.
module lfsr_gen #(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] GAL_TAPS = WIDTH'(8'h1D),
  parameter logic [WIDTH-1:0] FIB_TAPS = WIDTH'(8'hB8),
  parameter logic [WIDTH-1:0] SEED     = WIDTH'(8'hBD)
) (
  input logic       clk,
  input logic       rst_n,
  lfsr_gen_if.slave bus
);

  logic [WIDTH-1:0] out_q,    out_d;
  logic [WIDTH-1:0] anchor_q, anchor_d;
  logic [WIDTH-1:0] cnt_q,    cnt_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             period_vld_q, period_vld_d;
  logic             wrap_q,   wrap_d;
  logic             zero_err_q, zero_err_d;
  logic             mode_q,   mode_d;

  logic [WIDTH-1:0] gal_nxt;
  logic [WIDTH-1:0] fib_nxt;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] seed_eff;

  // Galois: MSB feeds bit 0 and is XORed into every tapped position on the shift.
  assign gal_nxt[0] = out_q[WIDTH-1];
  for (genvar i = 1; i < WIDTH; i++) begin : g_gal
    assign gal_nxt[i] = out_q[i-1] ^ (GAL_TAPS[i] & out_q[WIDTH-1]);
  end

  assign fib_nxt  = {out_q[WIDTH-2:0], ^(out_q & FIB_TAPS)};
  assign nxt      = mode_q ? fib_nxt : gal_nxt;
  assign seed_eff = (bus.seed_in != '0) ? bus.seed_in : SEED;

  always_comb begin
    out_d        = out_q;
    anchor_d     = anchor_q;
    cnt_d        = cnt_q;
    period_d     = period_q;
    period_vld_d = period_vld_q;
    wrap_d       = 1'b0;
    zero_err_d   = 1'b0;
    mode_d       = mode_q;

    if (bus.load) begin
      out_d        = seed_eff;
      anchor_d     = seed_eff;
      cnt_d        = '0;
      period_vld_d = 1'b0;
      zero_err_d   = (bus.seed_in == '0);
    end else if (bus.mode != mode_q) begin
      // Switching feedback starts a new sequence from wherever we are now.
      mode_d       = bus.mode;
      anchor_d     = out_q;
      cnt_d        = '0;
      period_vld_d = 1'b0;
    end else if (bus.en) begin
      out_d = nxt;
      if (nxt == anchor_q) begin
        wrap_d       = 1'b1;
        period_d     = cnt_q + WIDTH'(1);
        period_vld_d = 1'b1;
        cnt_d        = '0;
      end else begin
        cnt_d = cnt_q + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q        <= SEED;
      anchor_q     <= SEED;
      cnt_q        <= '0;
      period_q     <= '0;
      period_vld_q <= 1'b0;
      wrap_q       <= 1'b0;
      zero_err_q   <= 1'b0;
      mode_q       <= 1'b0;
    end else begin
      out_q        <= out_d;
      anchor_q     <= anchor_d;
      cnt_q        <= cnt_d;
      period_q     <= period_d;
      period_vld_q <= period_vld_d;
      wrap_q       <= wrap_d;
      zero_err_q   <= zero_err_d;
      mode_q       <= mode_d;
    end
  end

  assign bus.out        = out_q;
  assign bus.wrap       = wrap_q;
  assign bus.period     = period_q;
  assign bus.period_vld = period_vld_q;
  assign bus.zero_err   = zero_err_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// Directed vector table plus hand-written multi-cycle sequences for lfsr_gen.
module tb_lfsr_gen;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  lfsr_gen_if #(.WIDTH(8)) bus ();

  lfsr_gen #(
    .WIDTH   (8),
    .GAL_TAPS(8'h1D),
    .FIB_TAPS(8'hB8),
    .SEED    (8'hBD)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       load;
    logic       mode;
    logic [7:0] seed;
    logic [7:0] exp_out;
    logic       exp_wrap;
    logic       exp_vld;
    logic       exp_zerr;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.en      = 1'b0;
    bus.load    = 1'b0;
    bus.seed_in = 8'h00;
    bus.mode    = 1'b0;
    #2 rst_n = 1'b0;
    #7 rst_n = 1'b1;
    #1;
  endtask

  // Steps with en=1 until wrap pulses; steps counted from entry, bounded.
  task automatic run_to_wrap(input int start, output int steps);
    steps = start;
    bus.en = 1'b1;
    while (steps < 300) begin
      tick();
      steps++;
      if (bus.wrap) break;
    end
  endtask

  // Nonzero state invariant, checked on the falling edge while out of reset.
  always @(negedge clk) begin
    if (rst_n) begin
      assert (bus.out != 8'h00) else begin
        n_err++;
        $display("FAIL lockup: out is %0h, expected nonzero", bus.out);
      end
    end
  end

  initial begin
    int steps;
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b1;

    //           en    load  mode  seed   out    wrap  vld   zerr
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'hBD, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h67, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 8'h00, 8'hCE, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'hCE, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 8'h00, 8'hBD, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'hBD, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h02, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 8'h00, 8'h02, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 8'h00, 8'h04, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 8'h00, 8'h08, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 8'h00, 8'h11, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 1'b1, 8'hA5, 8'hA5, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 8'h00, 8'hA5, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h57, 1'b0, 1'b0, 1'b0};

    // Reset state
    do_reset();
    chk("rst_out", 32'(bus.out), 32'hBD);
    chk("rst_vld", 32'(bus.period_vld), 32'h0);
    chk("rst_wrap", 32'(bus.wrap), 32'h0);
    chk("rst_zerr", 32'(bus.zero_err), 32'h0);
    chk("rst_period", 32'(bus.period), 32'h0);

    // Directed table
    for (int i = 0; i < 15; i++) begin
      bus.en      = vecs[i].en;
      bus.load    = vecs[i].load;
      bus.mode    = vecs[i].mode;
      bus.seed_in = vecs[i].seed;
      tick();
      chk($sformatf("vec%0d_out", i), 32'(bus.out), 32'(vecs[i].exp_out));
      chk($sformatf("vec%0d_wrap", i), 32'(bus.wrap), 32'(vecs[i].exp_wrap));
      chk($sformatf("vec%0d_vld", i), 32'(bus.period_vld), 32'(vecs[i].exp_vld));
      chk($sformatf("vec%0d_zerr", i), 32'(bus.zero_err), 32'(vecs[i].exp_zerr));
    end

    // Galois full period from reset
    do_reset();
    bus.en = 1'b1;
    tick();
    chk("gal_first", 32'(bus.out), 32'h67);
    run_to_wrap(1, steps);
    chk("gal_steps", 32'(steps), 32'd255);
    chk("gal_period", 32'(bus.period), 32'd255);
    chk("gal_vld", 32'(bus.period_vld), 32'h1);
    chk("gal_out_at_wrap", 32'(bus.out), 32'hBD);
    tick();
    chk("gal_wrap_pulse", 32'(bus.wrap), 32'h0);
    chk("gal_vld_held", 32'(bus.period_vld), 32'h1);

    // Fibonacci full period; the mode-change cycle must not step
    do_reset();
    bus.mode = 1'b1;
    bus.en   = 1'b1;
    tick();
    chk("fib_nostep", 32'(bus.out), 32'hBD);
    tick();
    chk("fib_first", 32'(bus.out), 32'h7A);
    run_to_wrap(1, steps);
    chk("fib_steps", 32'(steps), 32'd255);
    chk("fib_period", 32'(bus.period), 32'd255);
    chk("fib_vld", 32'(bus.period_vld), 32'h1);

    // Zero-seed load with en=1: substitute seed, single zero_err pulse
    bus.load    = 1'b1;
    bus.seed_in = 8'h00;
    tick();
    chk("zload_out", 32'(bus.out), 32'hBD);
    chk("zload_err", 32'(bus.zero_err), 32'h1);
    chk("zload_vld", 32'(bus.period_vld), 32'h0);
    bus.load = 1'b0;
    bus.en   = 1'b0;
    tick();
    chk("zload_err_clr", 32'(bus.zero_err), 32'h0);
    chk("zload_hold", 32'(bus.out), 32'hBD);

    // Seed 01 Galois period, then a mid-run mode toggle re-anchors
    bus.load    = 1'b1;
    bus.seed_in = 8'h01;
    bus.mode    = 1'b0;
    tick();
    bus.load = 1'b0;
    tick();
    run_to_wrap(0, steps);
    chk("s01_steps", 32'(steps), 32'd255);
    chk("s01_out", 32'(bus.out), 32'h01);
    bus.en = 1'b1;
    repeat (100) tick();
    bus.mode = 1'b1;
    tick();
    chk("tog_vld_clr", 32'(bus.period_vld), 32'h0);
    run_to_wrap(0, steps);
    chk("tog_steps", 32'(steps), 32'd255);
    chk("tog_period", 32'(bus.period), 32'd255);

    // Asynchronous reset mid-run, released between edges
    bus.en   = 1'b1;
    bus.mode = 1'b0;
    repeat (20) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out", 32'(bus.out), 32'hBD);
    chk("arst_vld", 32'(bus.period_vld), 32'h0);
    chk("arst_wrap", 32'(bus.wrap), 32'h0);
    #1 rst_n = 1'b1;

    // Random en/load/mode soak; nonzero invariant watched on every falling edge
    for (int i = 0; i < 10000; i++) begin
      bus.en      = 1'($urandom_range(0, 1));
      bus.load    = ($urandom_range(0, 15) == 0);
      bus.mode    = ($urandom_range(0, 31) == 0) ? ~bus.mode : bus.mode;
      bus.seed_in = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      tick();
    end
    chk("soak_nonzero", 32'(bus.out != 8'h00), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
